// File: rtl/MD_pkg.sv
// -----------------------------------------------------------------------------
// MD_pkg
//   Shared constants and types for the MD position-initialisation path.
//   The init loader and its frame counter import these definitions.
//
//   Frame layout: one header beat (particles-per-cell in its low bits), then
//   NUM_INIT_STEPS * (npc + 1) particle beats. MD_init writes addresses
//   0..npc inclusive for each 4-cell group (one "step").
// -----------------------------------------------------------------------------
package MD_pkg;

  // Beat geometry: four 128-bit sub-packets per AXI-Stream beat.
  localparam int SUB_PACKET_WIDTH  = 128;
  localparam int AXIS_TDATA_WIDTH  = 4 * SUB_PACKET_WIDTH;

  // Particle indexing and cell/step layout.
  localparam int PARTICLE_ID_WIDTH = 8;
  localparam int NUM_CELLS         = 8;
  localparam int NUM_INIT_STEPS    = NUM_CELLS / 4;
  localparam int INIT_STEP_WIDTH   = 4;

  // Header field position and width of a full-frame beat count.
  localparam int INIT_HDR_NPC_LSB  = 0;
  localparam int INIT_BEATS_WIDTH  = PARTICLE_ID_WIDTH + INIT_STEP_WIDTH;

  // Loader FSM states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR_RST = 3'd1,
    LOAD    = 3'd2,
    DRAIN   = 3'd3,
    ERR     = 3'd4
  } init_ld_state_t;

  // Number of particle beats a frame must carry for a given npc:
  // NUM_INIT_STEPS * (npc + 1), unsigned, no saturation. Only used for
  // debug cross-checking; the datapath relies on the addr/step mirror.
  function automatic logic [INIT_BEATS_WIDTH-1:0] init_expected_beats(
    input logic [PARTICLE_ID_WIDTH-1:0] npc
  );
    logic [INIT_BEATS_WIDTH-1:0] per_step;
    per_step = INIT_BEATS_WIDTH'(npc) + INIT_BEATS_WIDTH'(1);
    return INIT_BEATS_WIDTH'(per_step * INIT_BEATS_WIDTH'(NUM_INIT_STEPS));
  endfunction

endpackage

// File: rtl/md_init_frame_cnt.sv
// -----------------------------------------------------------------------------
// md_init_frame_cnt
//   Mirror of MD_init's write-address / step counters. addr runs 0..npc, then
//   wraps to 0 and step increments. is_last flags the final beat position of
//   a frame (step == NUM_INIT_STEPS-1 and addr == npc), so the loader can
//   check frame length without a multiplier.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   clr      in   zero both counters (start of a new frame)
//   adv      in   advance by one accepted particle beat
//   npc      in   particles-per-cell for the current frame (held stable)
//   addr     out  current address within the step
//   step     out  current step index
//   is_last  out  current position is the final beat of the frame
// -----------------------------------------------------------------------------
module md_init_frame_cnt
  import MD_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         adv,
  input  logic [PARTICLE_ID_WIDTH-1:0] npc,
  output logic [PARTICLE_ID_WIDTH-1:0] addr,
  output logic [INIT_STEP_WIDTH-1:0]   step,
  output logic                         is_last
);

  localparam logic [INIT_STEP_WIDTH-1:0] LAST_STEP = INIT_STEP_WIDTH'(NUM_INIT_STEPS - 1);

  logic [PARTICLE_ID_WIDTH-1:0] addr_q, addr_d;
  logic [INIT_STEP_WIDTH-1:0]   step_q, step_d;
  logic                         addr_wrap;

  assign addr_wrap = (addr_q == npc);
  assign is_last   = addr_wrap && (step_q == LAST_STEP);

  always_comb begin
    addr_d = addr_q;
    step_d = step_q;
    if (clr) begin
      addr_d = '0;
      step_d = '0;
    end else if (adv) begin
      if (addr_wrap) begin
        addr_d = '0;
        // Wrap the step too at end of frame so the mirror is clean even if
        // the loader does not clear it before the next frame.
        step_d = is_last ? '0 : step_q + INIT_STEP_WIDTH'(1);
      end else begin
        addr_d = addr_q + PARTICLE_ID_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      step_q <= '0;
    end else begin
      addr_q <= addr_d;
      step_q <= step_d;
    end
  end

  assign addr = addr_q;
  assign step = step_q;

endmodule

// File: rtl/md_init_loader.sv
// -----------------------------------------------------------------------------
// md_init_loader
//   Front end of the position-initialisation path. Takes one init frame on
//   the host AXI-Stream (header beat with npc, then particle beats), strips
//   the header, pulses a clean reset to MD_init, and forwards each particle
//   beat one cycle later on o_init_tdata/o_init_tvalid. The frame length is
//   checked against the cell/step layout via an addr/step mirror counter.
//
// Ports:
//   clk             in   clock
//   rst             in   asynchronous active-low reset
//   s_axis_tdata    in   host beat
//   s_axis_tvalid   in   host valid
//   s_axis_tlast    in   last beat of the frame
//   s_axis_tready   out  loader ready (low while reset is asserted)
//   o_init_tdata    out  registered particle beat to MD_init
//   o_init_tvalid   out  one write per cycle to MD_init, never stalls
//   o_init_npc      out  latched particles-per-cell
//   o_init_sub_rst  out  one-cycle synchronous reset pulse to MD_init
//   o_init_done     out  one-cycle pulse on a correctly terminated frame
//   o_init_err      out  sticky frame-length error, cleared by next header
// -----------------------------------------------------------------------------
module md_init_loader
  import MD_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]  o_init_tdata,
  output logic                         o_init_tvalid,
  output logic [PARTICLE_ID_WIDTH-1:0] o_init_npc,
  output logic                         o_init_sub_rst,
  output logic                         o_init_done,
  output logic                         o_init_err
);

  init_ld_state_t               state_q, state_d;
  logic [AXIS_TDATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic                         tvalid_q, tvalid_d;
  logic [PARTICLE_ID_WIDTH-1:0] npc_q, npc_d;
  logic                         sub_rst_q, sub_rst_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;
  // Debug cross-check: beats required by the header vs beats actually loaded.
  logic [INIT_BEATS_WIDTH-1:0]  expected_q, expected_d;
  logic [INIT_BEATS_WIDTH-1:0]  beats_q, beats_d;

  logic                         ready;
  logic                         fire;
  logic                         cnt_clr;
  logic                         cnt_adv;
  logic                         cnt_is_last;
  logic [PARTICLE_ID_WIDTH-1:0] cnt_addr;
  logic [INIT_STEP_WIDTH-1:0]   cnt_step;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      IDLE, LOAD, ERR: ready = 1'b1;
      default:         ready = 1'b0;
    endcase
  end

  // The state register already sits in IDLE while reset is held; gating with
  // rst keeps the host from seeing a ready it cannot use.
  assign s_axis_tready = ready & rst;
  assign fire          = s_axis_tvalid & s_axis_tready;

  // ---------------------------------------------------------------------------
  // addr/step mirror of MD_init's counters
  // ---------------------------------------------------------------------------
  md_init_frame_cnt u_frame_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .clr     (cnt_clr),
    .adv     (cnt_adv),
    .npc     (npc_q),
    .addr    (cnt_addr),
    .step    (cnt_step),
    .is_last (cnt_is_last)
  );

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    tdata_d    = tdata_q;
    tvalid_d   = 1'b0;
    npc_d      = npc_q;
    sub_rst_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    expected_d = expected_q;
    beats_d    = beats_q;
    cnt_clr    = 1'b0;
    cnt_adv    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fire) begin
          npc_d      = s_axis_tdata[INIT_HDR_NPC_LSB +: PARTICLE_ID_WIDTH];
          expected_d = init_expected_beats(npc_d);
          beats_d    = '0;
          cnt_clr    = 1'b1;
          if (s_axis_tlast) begin
            // A header that is also the last beat is an empty frame.
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            err_d     = 1'b0;
            // Registered, so the pulse lands in the HDR_RST cycle.
            sub_rst_d = 1'b1;
            state_d   = HDR_RST;
          end
        end
      end

      HDR_RST: begin
        state_d = LOAD;
      end

      LOAD: begin
        if (fire) begin
          tdata_d  = s_axis_tdata;
          tvalid_d = 1'b1;
          cnt_adv  = 1'b1;
          beats_d  = beats_q + INIT_BEATS_WIDTH'(1);
          if (cnt_is_last) begin
            if (s_axis_tlast) begin
              state_d = DRAIN;
            end else begin
              // Host keeps sending past the frame: swallow until its tlast.
              err_d   = 1'b1;
              state_d = ERR;
            end
          end else if (s_axis_tlast) begin
            // Short frame. The host frame has already ended with this beat,
            // so there is nothing to discard; go straight back for a header.
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      DRAIN: begin
        // The last beat's tvalid is on the outputs this cycle; done follows.
        done_d  = 1'b1;
        state_d = IDLE;
      end

      ERR: begin
        if (fire && s_axis_tlast) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      npc_q      <= '0;
      sub_rst_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      expected_q <= '0;
      beats_q    <= '0;
    end else begin
      state_q    <= state_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      npc_q      <= npc_d;
      sub_rst_q  <= sub_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
      expected_q <= expected_d;
      beats_q    <= beats_d;
    end
  end

  assign o_init_tdata   = tdata_q;
  assign o_init_tvalid  = tvalid_q;
  assign o_init_npc     = npc_q;
  assign o_init_sub_rst = sub_rst_q;
  assign o_init_done    = done_q;
  assign o_init_err     = err_q;

  // ---------------------------------------------------------------------------
  // Debug properties
  // ---------------------------------------------------------------------------
  // MD_init must never see a write in the same cycle as its reset.
  a_no_rst_write_overlap : assert property (@(posedge clk) disable iff (!rst)
    !(o_init_sub_rst && o_init_tvalid));

  // A frame that reaches DRAIN carried exactly the header's beat count.
  a_drain_len : assert property (@(posedge clk) disable iff (!rst)
    (state_q == DRAIN) |-> (beats_q == expected_q));

  // The mirror counter starts every frame at the origin, like MD_init.
  a_cnt_origin : assert property (@(posedge clk) disable iff (!rst)
    (state_q == HDR_RST) |-> (cnt_addr == '0 && cnt_step == '0));

endmodule

// File: tb/tb_md_init_loader.sv
module tb_md_init_loader;

  localparam int DW    = 512;
  localparam int STEPS = 2;   // NUM_CELLS = 8 -> two 4-cell groups per frame

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] o_init_tdata;
  logic          o_init_tvalid;
  logic [7:0]    o_init_npc;
  logic          o_init_sub_rst;
  logic          o_init_done;
  logic          o_init_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int overlap = 0;

  // Monitor records (cycle index = negedge count)
  logic [DW-1:0] got_q[$];
  int            tv_cyc[$];
  int            acc_cyc[$];
  int            done_cyc[$];
  int            srst_cyc[$];
  logic [DW-1:0] sent_q[$];

  always #5 clk = ~clk;

  md_init_loader dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .o_init_tdata   (o_init_tdata),
    .o_init_tvalid  (o_init_tvalid),
    .o_init_npc     (o_init_npc),
    .o_init_sub_rst (o_init_sub_rst),
    .o_init_done    (o_init_done),
    .o_init_err     (o_init_err)
  );

  // Sample mid-cycle: outputs reflect the last posedge, inputs/ready predict
  // whether the next posedge accepts a beat.
  always @(negedge clk) begin
    cyc++;
    if (o_init_tvalid) begin
      got_q.push_back(o_init_tdata);
      tv_cyc.push_back(cyc);
    end
    if (o_init_done)    done_cyc.push_back(cyc);
    if (o_init_sub_rst) srst_cyc.push_back(cyc);
    if (o_init_sub_rst && o_init_tvalid) overlap++;
    if (s_axis_tvalid && s_axis_tready) acc_cyc.push_back(cyc);
  end

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: what a frame should produce, from the frame rules alone.
  function automatic void model(input int npc, input int nbeats, input int tlast_pos,
                                output int fwd, output bit done, output bit err);
    int need;
    need = STEPS * (npc + 1);
    if (tlast_pos != 0 && tlast_pos < need) begin
      fwd = tlast_pos; done = 1'b0; err = 1'b1;
    end else if (tlast_pos == need) begin
      fwd = need; done = 1'b1; err = 1'b0;
    end else begin
      fwd = (nbeats < need) ? nbeats : need;
      done = 1'b0;
      err = (nbeats >= need);
    end
  endfunction

  task automatic clear_mon();
    got_q.delete(); tv_cyc.delete(); acc_cyc.delete();
    done_cyc.delete(); srst_cyc.delete(); sent_q.delete();
    overlap = 0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l, input int gap_pct);
    bit ok;
    int budget;
    while ($urandom_range(99) < gap_pct) begin
      s_axis_tvalid = 1'b0;
      @(posedge clk); #1;
    end
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    ok = 1'b0;
    budget = 0;
    while (!ok && budget < 100) begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk); #1;
      budget++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: tready stayed %0b, required 1 within 100 cycles", s_axis_tready);
    end
  endtask

  task automatic drive_frame(input int npc, input int nbeats, input int tlast_pos,
                             input int gap_pct, input int tail);
    logic [DW-1:0] h;
    logic [DW-1:0] d;
    h = rand_beat();
    h[7:0] = npc[7:0];
    send_beat(h, 1'b0, 0);
    for (int k = 1; k <= nbeats; k++) begin
      d = rand_beat();
      sent_q.push_back(d);
      send_beat(d, (k == tlast_pos), gap_pct);
    end
    repeat (tail) begin @(posedge clk); #1; end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%0b exp=0", s_axis_tready); end
    total++;
    if ({o_init_tvalid, o_init_sub_rst, o_init_done, o_init_err} !== 4'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {o_init_tvalid, o_init_sub_rst, o_init_done, o_init_err});
    end
    total++;
    if (o_init_npc !== 8'd0 || o_init_tdata !== '0) begin
      bad++; $display("FAIL reset_data npc=%0d tdata_nonzero=%0b exp npc=0 tdata=0", o_init_npc, (o_init_tdata != '0));
    end
    rst = 1'b1;
    #1;
    total++;
    if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL reset_release_tready got=%0b exp=1", s_axis_tready); end
    @(posedge clk); #1;
    $display("reset: checked outputs during and after reset");
  endtask

  task automatic test_normal();
    int fwd; bit dn; bit er;
    clear_mon();
    drive_frame(3, 8, 8, 0, 4);
    model(3, 8, 8, fwd, dn, er);
    total++;
    if (got_q.size() !== fwd) begin bad++; $display("FAIL normal_count got=%0d exp=%0d", got_q.size(), fwd); end
    for (int i = 0; i < fwd && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== sent_q[i] || tv_cyc[i] !== acc_cyc[i+1] + 1) begin
        bad++; $display("FAIL normal_beat%0d data_ok=%0b tv_cyc=%0d exp_cyc=%0d", i, got_q[i] === sent_q[i], tv_cyc[i], acc_cyc[i+1] + 1);
      end
    end
    total++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== acc_cyc[acc_cyc.size()-1] + 2) begin
      bad++; $display("FAIL normal_done count=%0d exp_count=%0d", done_cyc.size(), int'(dn));
    end
    total++;
    if (o_init_err !== er) begin bad++; $display("FAIL normal_err got=%0b exp=%0b", o_init_err, er); end
    total++;
    if (o_init_npc !== 8'd3) begin bad++; $display("FAIL normal_npc got=%0d exp=3", o_init_npc); end
    total++;
    if (srst_cyc.size() !== 1 || srst_cyc[0] !== acc_cyc[0] + 1 || overlap !== 0) begin
      bad++; $display("FAIL normal_sub_rst count=%0d overlap=%0d exp count=1 overlap=0", srst_cyc.size(), overlap);
    end
    $display("normal: npc=3 forwarded=%0d done=%0d err=%0b", got_q.size(), done_cyc.size(), o_init_err);
  endtask

  task automatic test_npc0();
    int fwd; bit dn; bit er;
    clear_mon();
    drive_frame(0, STEPS, STEPS, 0, 4);
    model(0, STEPS, STEPS, fwd, dn, er);
    total++;
    if (got_q.size() !== fwd) begin bad++; $display("FAIL npc0_count got=%0d exp=%0d", got_q.size(), fwd); end
    for (int i = 0; i < fwd && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== sent_q[i]) begin bad++; $display("FAIL npc0_beat%0d data differs from input", i); end
    end
    total++;
    if (done_cyc.size() !== int'(dn) || o_init_err !== er) begin
      bad++; $display("FAIL npc0_done done=%0d err=%0b exp done=%0d err=%0b", done_cyc.size(), o_init_err, int'(dn), er);
    end
    $display("npc0: forwarded=%0d done=%0d", got_q.size(), done_cyc.size());
  endtask

  task automatic test_early_tlast();
    int fwd; bit dn; bit er;
    clear_mon();
    drive_frame(3, 5, 5, 0, 3);
    model(3, 5, 5, fwd, dn, er);
    total++;
    if (got_q.size() !== fwd) begin bad++; $display("FAIL early_count got=%0d exp=%0d", got_q.size(), fwd); end
    total++;
    if (o_init_err !== er || done_cyc.size() !== int'(dn)) begin
      bad++; $display("FAIL early_err err=%0b done=%0d exp err=%0b done=%0d", o_init_err, done_cyc.size(), er, int'(dn));
    end
    // Loader must be back in IDLE: the next header triggers a sub reset.
    clear_mon();
    drive_frame(1, 4, 4, 0, 4);
    total++;
    if (srst_cyc.size() !== 1 || srst_cyc[0] !== acc_cyc[0] + 1 || done_cyc.size() !== 1 || o_init_err !== 1'b0) begin
      bad++; $display("FAIL early_recover sub_rst=%0d done=%0d err=%0b exp 1 1 0", srst_cyc.size(), done_cyc.size(), o_init_err);
    end
    $display("early_tlast: forwarded=%0d then recovered", fwd);
  endtask

  task automatic test_missing_tlast();
    int fwd; bit dn; bit er;
    clear_mon();
    drive_frame(3, 10, 10, 0, 3);
    model(3, 10, 10, fwd, dn, er);
    total++;
    if (got_q.size() !== fwd) begin bad++; $display("FAIL missing_count got=%0d exp=%0d", got_q.size(), fwd); end
    for (int i = 0; i < fwd && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== sent_q[i]) begin bad++; $display("FAIL missing_beat%0d data differs from input", i); end
    end
    total++;
    if (o_init_err !== er || done_cyc.size() !== int'(dn) || acc_cyc.size() !== 11) begin
      bad++; $display("FAIL missing_err err=%0b done=%0d accepted=%0d exp err=1 done=0 accepted=11", o_init_err, done_cyc.size(), acc_cyc.size());
    end
    clear_mon();
    drive_frame(0, STEPS, STEPS, 0, 4);
    total++;
    if (srst_cyc.size() !== 1 || done_cyc.size() !== 1 || o_init_err !== 1'b0) begin
      bad++; $display("FAIL missing_recover sub_rst=%0d done=%0d err=%0b exp 1 1 0", srst_cyc.size(), done_cyc.size(), o_init_err);
    end
    $display("missing_tlast: forwarded=%0d discarded=2", fwd);
  endtask

  task automatic test_gaps();
    int npc; int n; int fwd; bit dn; bit er;
    npc = $urandom_range(1, 4);
    n = STEPS * (npc + 1);
    clear_mon();
    drive_frame(npc, n, n, 50, 4);
    model(npc, n, n, fwd, dn, er);
    total++;
    if (got_q.size() !== fwd) begin bad++; $display("FAIL gaps_count got=%0d exp=%0d", got_q.size(), fwd); end
    for (int i = 0; i < fwd && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== sent_q[i] || tv_cyc[i] !== acc_cyc[i+1] + 1) begin
        bad++; $display("FAIL gaps_beat%0d data_ok=%0b tv_cyc=%0d exp_cyc=%0d", i, got_q[i] === sent_q[i], tv_cyc[i], acc_cyc[i+1] + 1);
      end
    end
    total++;
    if (srst_cyc.size() !== 1 || srst_cyc[0] !== acc_cyc[0] + 1) begin
      bad++; $display("FAIL gaps_sub_rst count=%0d cyc=%0d exp_cyc=%0d", srst_cyc.size(), srst_cyc[0], acc_cyc[0] + 1);
    end
    total++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== acc_cyc[acc_cyc.size()-1] + 2 || o_init_err !== er) begin
      bad++; $display("FAIL gaps_done count=%0d err=%0b exp count=1 err=0", done_cyc.size(), o_init_err);
    end
    $display("gaps: npc=%0d forwarded=%0d", npc, got_q.size());
  endtask

  task automatic test_reset_mid();
    clear_mon();
    drive_frame(3, 3, 0, 0, 0);
    total++;
    if (o_init_tvalid !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid got=%0b exp=1", o_init_tvalid); end
    rst = 1'b0;
    #1;
    total++;
    if ({o_init_tvalid, o_init_sub_rst, o_init_done, o_init_err, s_axis_tready} !== 5'b0 ||
        o_init_npc !== 8'd0 || o_init_tdata !== '0) begin
      bad++; $display("FAIL midrst_outputs flags=%b npc=%0d exp all zero",
                      {o_init_tvalid, o_init_sub_rst, o_init_done, o_init_err, s_axis_tready}, o_init_npc);
    end
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    drive_frame(1, 4, 4, 0, 4);
    total++;
    if (got_q.size() !== 4 || got_q[0] !== sent_q[0] || got_q[3] !== sent_q[3]) begin
      bad++; $display("FAIL midrst_frame count=%0d exp=4", got_q.size());
    end
    total++;
    if (srst_cyc.size() !== 1 || srst_cyc[0] !== acc_cyc[0] + 1 || done_cyc.size() !== 1 || o_init_err !== 1'b0) begin
      bad++; $display("FAIL midrst_recover sub_rst=%0d done=%0d err=%0b exp 1 1 0", srst_cyc.size(), done_cyc.size(), o_init_err);
    end
    $display("reset_mid: new frame forwarded=%0d done=%0d", got_q.size(), done_cyc.size());
  endtask

  task automatic test_back_to_back();
    int nf;
    nf = 4;
    clear_mon();
    for (int f = 0; f < nf; f++) begin
      int npc; int n;
      npc = $urandom_range(0, 5);
      n = STEPS * (npc + 1);
      drive_frame(npc, n, n, $urandom_range(0, 60), (f == nf - 1) ? 4 : 0);
    end
    total++;
    if (got_q.size() !== sent_q.size()) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), sent_q.size()); end
    for (int i = 0; i < sent_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== sent_q[i]) begin bad++; $display("FAIL b2b_beat%0d data differs from input", i); end
    end
    total++;
    if (done_cyc.size() !== nf || srst_cyc.size() !== nf || o_init_err !== 1'b0 || overlap !== 0) begin
      bad++; $display("FAIL b2b_frames done=%0d sub_rst=%0d err=%0b overlap=%0d exp %0d %0d 0 0",
                      done_cyc.size(), srst_cyc.size(), o_init_err, overlap, nf, nf);
    end
    $display("back_to_back: frames=%0d beats=%0d", nf, got_q.size());
  endtask

  initial begin
    test_reset();
    test_normal();
    test_npc0();
    test_early_tlast();
    test_missing_tlast();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
